text_key_stream_memory: RTL

- Parametrised, writable successor to the fixed text/key ROM feeding the AES datapath.
- Holds DEPTH text blocks and KEY_SLOTS round keys. Delivers a {text, key} pair per transfer over a valid/ready handshake.
- Two read modes: random-access by pc_i, and streaming (auto-incrementing address with wrap-around and a burst-done pulse).
- Sits between the testbench/host loader and the AES encrypt/decrypt core.

---
 rtl/text_key_stream_memory.sv | 98 +++++++++
 1 files changed

// File: rtl/text_key_stream_memory.sv
// text_key_stream_memory: writable text/key store delivering {text, key} pairs
// over valid/ready, either one random-access read or an auto-incrementing wrapped burst.
module text_key_stream_memory #(
    parameter int TEXT_WIDTH = 128,
    parameter int KEY_WIDTH  = 128,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int KEY_SLOTS  = 2,
    parameter int KSEL_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic                  wr_sel_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [TEXT_WIDTH-1:0] wr_data_i,
    input  logic                  mode_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [KSEL_WIDTH-1:0] key_sel_i,
    input  logic                  ready_i,
    output logic [TEXT_WIDTH-1:0] text_q,
    output logic [KEY_WIDTH-1:0]  key_q,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  busy_o,
    output logic                  done_o
);
    typedef enum logic [1:0] {IDLE, LOAD, PRESENT} state_t;

    logic [TEXT_WIDTH-1:0] text_mem [DEPTH];
    logic [KEY_WIDTH-1:0]  keys     [KEY_SLOTS];
    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  mode;
    logic [KSEL_WIDTH-1:0] ksel;
    logic [KSEL_WIDTH-1:0] wr_ksel;

    assign wr_ksel = wr_addr_i[KSEL_WIDTH-1:0];

    // Arrays are deliberately unreset so loaded contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !wr_sel_i)
            text_mem[wr_addr_i] <= wr_data_i;
        else if (wr_en_i && 32'(wr_ksel) < KEY_SLOTS)
            keys[wr_ksel] <= wr_data_i[KEY_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            addr    <= '0;
            cnt     <= '0;
            mode    <= 1'b0;
            ksel    <= '0;
            text_q  <= '0;
            key_q   <= '0;
            valid_o <= 1'b0;
            addr_o  <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (req_i) begin
                    mode   <= mode_i;
                    addr   <= pc_i;
                    cnt    <= (len_i == '0) ? (ADDR_WIDTH+1)'(1) : len_i;
                    ksel   <= key_sel_i;
                    busy_o <= 1'b1;
                    state  <= LOAD;
                end
                LOAD: begin
                    text_q  <= text_mem[addr];
                    key_q   <= keys[ksel];
                    addr_o  <= addr;
                    valid_o <= 1'b1;
                    state   <= PRESENT;
                end
                PRESENT: if (ready_i) begin
                    valid_o <= 1'b0;
                    if (!mode || cnt <= (ADDR_WIDTH+1)'(1)) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        addr  <= addr + ADDR_WIDTH'(1);
                        cnt   <= cnt - (ADDR_WIDTH+1)'(1);
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
